// File: rtl/vending_machine_pkg.sv
// Shared types, money constants and pricing helpers for the vending machine.
// All money values are in rupees and fit the 7-bit money width.
package vending_machine_pkg;

    localparam int unsigned MoneyWidth = 7;

    typedef logic [MoneyWidth-1:0] money_t;

    localparam money_t CoinFive = 7'd5;
    localparam money_t CoinTen  = 7'd10;
    localparam money_t MoneyMax = 7'd125;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDispense,
        StChange
    } state_e;

    // Price of item n is 5*(n+1).
    function automatic money_t item_price(input logic [3:0] item);
        money_t n1;
        n1 = {3'b000, item} + 7'd1;
        return (n1 << 2) + n1;
    endfunction

    // Clamp an 8-bit intermediate sum into the 7-bit money range.
    function automatic money_t money_sat(input logic [MoneyWidth:0] value);
        if (value > {1'b0, MoneyMax}) begin
            return MoneyMax;
        end
        return value[MoneyWidth-1:0];
    endfunction

endpackage

// File: rtl/vending_machine_if.sv
// Customer-facing bundle of the vending machine: item select, coin inputs and outputs.
// master drives selection and coins; slave is the machine itself.
interface vending_machine_if;

    logic [3:0] item_number;
    logic       rupee_five_in;
    logic       rupee_ten_in;
    logic       rupee_five_out;
    logic       dispense;

    modport master (
        output item_number,
        output rupee_five_in,
        output rupee_ten_in,
        input  rupee_five_out,
        input  dispense
    );

    modport slave (
        input  item_number,
        input  rupee_five_in,
        input  rupee_ten_in,
        output rupee_five_out,
        output dispense
    );

endinterface

// File: rtl/vm_price_table.sv
// Combinational item price lookup: 4-bit item index in, 7-bit price out.
module vm_price_table
    import vending_machine_pkg::*;
(
    input  logic [3:0] item,
    output money_t     price
);

    assign price = item_price(item);

endmodule

// File: rtl/vending_machine.sv
// Moore vending machine: collects Rs5/Rs10 coins, dispenses the latched item and pays
// change (plus refunds of coins inserted while dispensing or paying change) in Rs5 coins.
module vending_machine
    import vending_machine_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    vending_machine_if.slave  vm
);

    state_e     state_q, state_d;
    money_t     credit_q, credit_d;
    money_t     change_q, change_d;
    logic [3:0] item_q, item_d;

    money_t               coin;
    money_t               price;
    logic [3:0]           price_item;
    logic [MoneyWidth:0]  sum;

    assign coin = (vm.rupee_five_in ? CoinFive : 7'd0) + (vm.rupee_ten_in ? CoinTen : 7'd0);

    // In IDLE the item is being latched this edge, so price the live selection.
    assign price_item = (state_q == StIdle) ? vm.item_number : item_q;

    vm_price_table u_price_table (
        .item  (price_item),
        .price (price)
    );

    assign sum = {1'b0, credit_q} + {1'b0, coin};

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        item_d   = item_q;

        unique case (state_q)
            StIdle, StCollect: begin
                if (state_q == StIdle) begin
                    credit_d = 7'd0;
                end
                if ((state_q == StCollect) || (coin != 7'd0)) begin
                    if (state_q == StIdle) begin
                        item_d = vm.item_number;
                    end
                    if (sum >= {1'b0, price}) begin
                        state_d  = StDispense;
                        change_d = money_sat(sum - {1'b0, price});
                        credit_d = 7'd0;
                    end else begin
                        state_d  = StCollect;
                        credit_d = sum[MoneyWidth-1:0];
                    end
                end
            end
            StDispense: begin
                credit_d = 7'd0;
                change_d = money_sat({1'b0, change_q} + {1'b0, coin});
                state_d  = (change_d != 7'd0) ? StChange : StIdle;
            end
            StChange: begin
                // change_q is always a nonzero multiple of 5 here, so the subtraction is safe.
                credit_d = 7'd0;
                change_d = money_sat({1'b0, change_q} - {1'b0, CoinFive} + {1'b0, coin});
                state_d  = (change_d != 7'd0) ? StChange : StIdle;
            end
            default: begin
                state_d  = StIdle;
                credit_d = 7'd0;
                change_d = 7'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            credit_q <= 7'd0;
            change_q <= 7'd0;
            item_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            item_q   <= item_d;
        end
    end

    // Outputs are forced low while reset is held, even before the reset edge lands.
    assign vm.dispense       = reset && (state_q == StDispense);
    assign vm.rupee_five_out = reset && (state_q == StChange);

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine; each scenario compares the
// chronological dispense / rupee_five_out pulse trains against hand-derived patterns.
module tb_vending_machine;

    logic clock = 1'b0;
    logic reset = 1'b0;

    vending_machine_if vm_bus ();

    vending_machine dut (
        .clock (clock),
        .reset (reset),
        .vm    (vm_bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int both_cnt = 0;

    task automatic cycle(input logic f, input logic t, output logic d, output logic c);
        vm_bus.rupee_five_in = f;
        vm_bus.rupee_ten_in  = t;
        @(posedge clock);
        #1;
        d = vm_bus.dispense;
        c = vm_bus.rupee_five_out;
        if (d && c) both_cnt++;
        vm_bus.rupee_five_in = 1'b0;
        vm_bus.rupee_ten_in  = 1'b0;
    endtask

    // Step i uses bit (n-1-i) of the coin vectors; results shift in so the
    // leftmost bit of an n-bit literal is the first cycle.
    task automatic run_seq(input int n, input logic [31:0] fives, input logic [31:0] tens,
                           output logic [31:0] dv, output logic [31:0] fv);
        logic d, c;
        dv = '0;
        fv = '0;
        for (int i = 0; i < n; i++) begin
            cycle(fives[n-1-i], tens[n-1-i], d, c);
            dv = {dv[30:0], d};
            fv = {fv[30:0], c};
        end
    endtask

    task automatic do_reset();
        vm_bus.rupee_five_in = 1'b0;
        vm_bus.rupee_ten_in  = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic d, c;
        vm_bus.item_number   = 4'd0;
        vm_bus.rupee_ten_in  = 1'b1;
        vm_bus.rupee_five_in = 1'b1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (vm_bus.dispense !== 1'b0) begin
            failures++;
            $display("FAIL reset_dispense got=%b exp=0", vm_bus.dispense);
        end
        checks++;
        if (vm_bus.rupee_five_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_five_out got=%b exp=0", vm_bus.rupee_five_out);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(1'b0, 1'b0, d, c);
        checks++;
        if ({d, c} !== 2'b00) begin
            failures++;
            $display("FAIL reset_first_cycle got=%b exp=00", {d, c});
        end
    endtask

    task automatic test_item2_exact();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd2;
        run_seq(3, 3'b100, 3'b010, dv, fv);
        checks++;
        if (dv !== 32'b010) begin
            failures++;
            $display("FAIL item2_exact dispense got=%0b exp=010", dv);
        end
        checks++;
        if (fv !== 32'b000) begin
            failures++;
            $display("FAIL item2_exact five_out got=%0b exp=000", fv);
        end
    endtask

    task automatic test_item2_change();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd2;
        run_seq(5, 5'b00000, 5'b11000, dv, fv);
        checks++;
        if (dv !== 32'b01000) begin
            failures++;
            $display("FAIL item2_change dispense got=%0b exp=1000", dv);
        end
        checks++;
        if (fv !== 32'b00100) begin
            failures++;
            $display("FAIL item2_change five_out got=%0b exp=100", fv);
        end
    endtask

    task automatic test_item0_both();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd0;
        run_seq(4, 4'b1000, 4'b1000, dv, fv);
        checks++;
        if (dv !== 32'b1000) begin
            failures++;
            $display("FAIL item0_both dispense got=%0b exp=1000", dv);
        end
        checks++;
        if (fv !== 32'b0110) begin
            failures++;
            $display("FAIL item0_both five_out got=%0b exp=110", fv);
        end
    endtask

    task automatic test_item_latch();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd15;
        run_seq(7, 7'b0, 7'b1111111, dv, fv);
        checks++;
        if (dv !== 32'b0) begin
            failures++;
            $display("FAIL latch15_early dispense got=%0b exp=0", dv);
        end
        vm_bus.item_number = 4'd0;
        run_seq(2, 2'b00, 2'b10, dv, fv);
        checks++;
        if (dv !== 32'b10) begin
            failures++;
            $display("FAIL latch15_final dispense got=%0b exp=10", dv);
        end
        checks++;
        if (fv !== 32'b00) begin
            failures++;
            $display("FAIL latch15_final five_out got=%0b exp=0", fv);
        end
        // Item 1 (price 10) latched; re-selecting item 0 must not create change.
        do_reset();
        vm_bus.item_number = 4'd1;
        run_seq(1, 1'b1, 1'b0, dv, fv);
        vm_bus.item_number = 4'd0;
        run_seq(3, 3'b100, 3'b000, dv, fv);
        checks++;
        if ({dv[2:0], fv[2:0]} !== 6'b100_000) begin
            failures++;
            $display("FAIL latch1 dispense/five got=%b exp=100000", {dv[2:0], fv[2:0]});
        end
    endtask

    task automatic test_reset_mid_purchase();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd3;
        run_seq(1, 1'b0, 1'b1, dv, fv);
        reset = 1'b0;
        vm_bus.rupee_ten_in = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({vm_bus.dispense, vm_bus.rupee_five_out} !== 2'b00) begin
            failures++;
            $display("FAIL rst_purchase outputs got=%b exp=00",
                     {vm_bus.dispense, vm_bus.rupee_five_out});
        end
        vm_bus.rupee_ten_in = 1'b0;
        reset = 1'b1;
        run_seq(3, 3'b000, 3'b000, dv, fv);
        checks++;
        if ({dv[2:0], fv[2:0]} !== 6'b0) begin
            failures++;
            $display("FAIL rst_purchase idle got=%b exp=000000", {dv[2:0], fv[2:0]});
        end
        run_seq(2, 2'b00, 2'b11, dv, fv);
        checks++;
        if (dv !== 32'b01) begin
            failures++;
            $display("FAIL rst_purchase credit dispense got=%0b exp=01", dv);
        end
        checks++;
        if (fv !== 32'b00) begin
            failures++;
            $display("FAIL rst_purchase credit five_out got=%0b exp=0", fv);
        end
    endtask

    task automatic test_reset_mid_change();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd0;
        run_seq(2, 2'b10, 2'b10, dv, fv);
        checks++;
        if (fv !== 32'b01) begin
            failures++;
            $display("FAIL rst_change pre five_out got=%0b exp=01", fv);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (vm_bus.rupee_five_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_change during five_out got=%b exp=0", vm_bus.rupee_five_out);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_seq(3, 3'b000, 3'b000, dv, fv);
        checks++;
        if (fv !== 32'b000) begin
            failures++;
            $display("FAIL rst_change after five_out got=%0b exp=0", fv);
        end
    endtask

    task automatic test_refund_dispense();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd2;
        run_seq(8, 8'b10000010, 8'b01100000, dv, fv);
        checks++;
        if (dv !== 32'b01000000) begin
            failures++;
            $display("FAIL refund_disp dispense got=%0b exp=1000000", dv);
        end
        checks++;
        if (fv !== 32'b00110000) begin
            failures++;
            $display("FAIL refund_disp five_out got=%0b exp=110000", fv);
        end
        // With purchase change of 5 pending, the refund adds two more pulses.
        do_reset();
        run_seq(7, 7'b0000000, 7'b1110000, dv, fv);
        checks++;
        if (dv !== 32'b0100000) begin
            failures++;
            $display("FAIL refund_disp_chg dispense got=%0b exp=100000", dv);
        end
        checks++;
        if (fv !== 32'b0011100) begin
            failures++;
            $display("FAIL refund_disp_chg five_out got=%0b exp=11100", fv);
        end
    endtask

    task automatic test_refund_change();
        logic [31:0] dv, fv;
        do_reset();
        vm_bus.item_number = 4'd0;
        run_seq(6, 6'b000000, 6'b101000, dv, fv);
        checks++;
        if (dv !== 32'b100000) begin
            failures++;
            $display("FAIL refund_chg dispense got=%0b exp=100000", dv);
        end
        checks++;
        if (fv !== 32'b011100) begin
            failures++;
            $display("FAIL refund_chg five_out got=%0b exp=11100", fv);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] dv, fv;
        logic        d, c;
        int          pulses;
        do_reset();
        vm_bus.item_number = 4'd0;
        run_seq(16, 16'hFFFF, 16'hFFFF, dv, fv);
        checks++;
        if ({dv[15:0], fv[15:0]} !== {16'h8000, 16'h7FFF}) begin
            failures++;
            $display("FAIL sat_fill got=%h exp=80007fff", {dv[15:0], fv[15:0]});
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, d, c);
            if (c) pulses++;
        end
        checks++;
        if (pulses !== 24) begin
            failures++;
            $display("FAIL sat_drain pulses got=%0d exp=24", pulses);
        end
        checks++;
        if ({d, c} !== 2'b00) begin
            failures++;
            $display("FAIL sat_drain idle got=%b exp=00", {d, c});
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL exclusive both_high_cycles got=%0d exp=0", both_cnt);
        end
    endtask

    initial begin
        vm_bus.item_number   = 4'd0;
        vm_bus.rupee_five_in = 1'b0;
        vm_bus.rupee_ten_in  = 1'b0;
        test_reset();
        test_item2_exact();
        test_item2_change();
        test_item0_both();
        test_item_latch();
        test_reset_mid_purchase();
        test_reset_mid_change();
        test_refund_dispense();
        test_refund_change();
        test_saturation();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
